fpu_issuer: RTL and testbench

FPU_ISSUER -- requirements
Module: fpu_issuer

---
 rtl/fpu_issuer_if.sv | 43 ++++
 rtl/fpu_issuer.sv | 139 +++++++++++++
 tb/tb_fpu_issuer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issuer_if.sv
// Command, FPU-side and result handshake signals of the FPU issuer.
// The slave modport is the issuer's view; master is the surrounding environment.
interface fpu_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_x1;
  logic [4:0]  cmd_x2;
  logic [4:0]  cmd_y;
  logic [31:0] cmd_data;

  logic [4:0]  x1;
  logic [4:0]  x2;
  logic [4:0]  y;
  logic [5:0]  operation;
  logic [31:0] in_data;
  logic        ready;
  logic        valid;
  logic        cond;
  logic [31:0] out_data;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_cond;

  logic        busy;
  logic        err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
    input  valid, cond, out_data, res_ready,
    output cmd_ready, x1, x2, y, operation, in_data, ready,
    output res_valid, res_data, res_cond, busy, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
    output valid, cond, out_data, res_ready,
    input  cmd_ready, x1, x2, y, operation, in_data, ready,
    input  res_valid, res_data, res_cond, busy, err
  );
endinterface

// File: rtl/fpu_issuer.sv
// Queues FPU commands in a small FIFO and issues them one at a time, holding each on the
// FPU side until valid or timeout; results are held on a backpressured result port.
module fpu_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rstn,
  fpu_issuer_if.slave  bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = 6 + 5 + 5 + 5 + 32;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  // Last ISSUE cycle index before giving up; ready is held at most TIMEOUT cycles.
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          init_q;
  logic          empty, full, push, pop;
  logic [EW-1:0] wr_entry;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] fields_q, fields_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_cond_q, res_cond_d;
  logic          err_q, err_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // init_q keeps cmd_ready low until the first edge after reset release.
  assign bus_io.cmd_ready = init_q & ~full;
  assign push             = bus_io.cmd_valid & init_q & ~full;
  assign pop              = (state_q == StIdle) & ~empty & ~res_valid_q;

  assign wr_entry = {bus_io.cmd_op, bus_io.cmd_x1, bus_io.cmd_x2, bus_io.cmd_y, bus_io.cmd_data};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fields_d    = fields_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cond_d  = res_cond_q;
    err_d       = err_q;

    if (res_valid_q && bus_io.res_ready) begin
      res_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d  = StIssue;
          fields_d = mem_q[rptr_q[AW-1:0]];
          cnt_d    = '0;
        end
      end
      StIssue: begin
        // valid takes priority over an expiring count.
        if (bus_io.valid) begin
          res_data_d  = bus_io.out_data;
          res_cond_d  = bus_io.cond;
          res_valid_d = 1'b1;
          state_d     = StIdle;
          fields_d    = '0;
          cnt_d       = '0;
        end else if (cnt_q == CntLast) begin
          err_d    = 1'b1;
          state_d  = StIdle;
          fields_d = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        fields_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fields_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cond_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fields_q    <= fields_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cond_q  <= res_cond_d;
      err_q       <= err_d;
    end
  end

  assign {bus_io.operation, bus_io.x1, bus_io.x2, bus_io.y, bus_io.in_data} = fields_q;
  assign bus_io.ready     = (state_q == StIssue);
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_data  = res_data_q;
  assign bus_io.res_cond  = res_cond_q;
  assign bus_io.busy      = ~empty | (state_q != StIdle);
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_fpu_issuer.sv
// Directed and randomized bench for fpu_issuer: an in-order command/result scoreboard with an
// FPU responder of configurable latency, checked every cycle on the falling clock edge.
module tb_fpu_issuer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } cmd_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fpu_issuer_if bus ();

  fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rstn(rstn), .bus_io(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  cmd_t        drv_q[$];   // waiting to be offered upstream
  cmd_t        iss_q[$];   // accepted by the DUT, not yet issued
  logic [32:0] res_q[$];   // {cond, data} expected on the result port
  cmd_t        cur;
  int          lat      = 1;  // 0: FPU never answers
  bit          rand_lat = 0;
  int          rr_mode  = 1;  // 0 hold, 1 always ready, 2 random
  bit          fix_en   = 0;
  logic [31:0] fix_val  = '0;
  bit          prev_ready, prev_res_valid, exp_cap, exp_to, exp_clear, err_exp;
  int          age, last_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.op   = 6'($urandom);
    c.x1   = 5'($urandom);
    c.x2   = 5'($urandom);
    c.y    = 5'($urandom);
    c.data = $urandom;
    return c;
  endfunction

  task automatic clear_model();
    drv_q.delete();
    iss_q.delete();
    res_q.delete();
    prev_ready = 0; prev_res_valid = 0; exp_cap = 0; exp_to = 0; exp_clear = 0;
    err_exp = 0; age = 0;
  endtask

  task automatic cycle();
    cmd_t        obs;
    bit          rdy;
    logic [31:0] r;
    @(negedge clk);
    rdy = bus.ready;
    obs = {bus.operation, bus.x1, bus.x2, bus.y, bus.in_data};
    if (exp_cap) begin
      chk("cap_ready_low", rdy, 0);
      chk("cap_res_valid", bus.res_valid, 1);
      exp_cap = 0;
    end
    if (exp_to) begin
      chk("to_ready_low", rdy, 0);
      chk("to_no_result", bus.res_valid, 0);
      err_exp = 1;
      exp_to  = 0;
    end
    if (exp_clear) begin
      chk("res_clear", bus.res_valid, 0);
      exp_clear = 0;
    end
    chk("err", bus.err, err_exp);
    if (prev_ready && !rdy) last_len = age;
    if (rdy && !prev_ready) begin
      chk("issue_while_result", prev_res_valid, 0);
      chk("issue_expected", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) cur = iss_q.pop_front();
      age = 0;
      if (rand_lat) lat = $urandom_range(0, TIMEOUT + 2);
    end
    if (rdy) begin
      chk("fields", obs, cur);
      age++;
    end else begin
      chk("fields_zero", obs, 0);
    end
    chk("cmd_ready", bus.cmd_ready, iss_q.size() < DEPTH);
    chk("busy", bus.busy, (iss_q.size() != 0) || rdy);
    if (bus.res_valid) begin
      chk("res_expected", res_q.size() != 0, 1);
      if (res_q.size() != 0) chk("res_data", {bus.res_cond, bus.res_data}, res_q[0]);
    end

    // Drive inputs for the next rising edge.
    if (drv_q.size() != 0) begin
      bus.cmd_valid = 1'b1;
      {bus.cmd_op, bus.cmd_x1, bus.cmd_x2, bus.cmd_y, bus.cmd_data} = drv_q[0];
      if (bus.cmd_ready) iss_q.push_back(drv_q.pop_front());
    end else begin
      bus.cmd_valid = 1'b0;
    end
    r = $urandom;
    if (rdy && lat != 0 && age == lat) begin
      bus.valid    = 1'b1;
      bus.out_data = fix_en ? fix_val : $urandom;
      bus.cond     = fix_en ? 1'b0 : r[0];
      res_q.push_back({bus.cond, bus.out_data});
      exp_cap = 1;
    end else begin
      // Junk valid while ready is low must be ignored.
      bus.valid    = rdy ? 1'b0 : r[1];
      bus.out_data = $urandom;
      bus.cond     = r[2];
      if (rdy && age == int'(TIMEOUT)) exp_to = 1;
    end
    case (rr_mode)
      0:       bus.res_ready = 1'b0;
      1:       bus.res_ready = 1'b1;
      default: bus.res_ready = r[3];
    endcase
    if (bus.res_valid && bus.res_ready) begin
      if (res_q.size() != 0) res_q.delete(0);
      exp_clear = 1;
    end
    prev_ready     = rdy;
    prev_res_valid = bus.res_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((drv_q.size() != 0 || iss_q.size() != 0 || prev_ready || res_q.size() != 0)
           && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    run(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_x1 = '0; bus.cmd_x2 = '0; bus.cmd_y = '0;
    bus.cmd_data = '0; bus.valid = 0; bus.cond = 0; bus.out_data = '0; bus.res_ready = 0;
    clear_model();
    last_len = 0;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_res", {bus.res_valid, bus.res_cond, bus.res_data}, 0);
    rstn = 1'b1;
    cycle();
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // Single SET with latency 3 and fixed result
    lat = 3; fix_en = 1; fix_val = 32'h3f800000;
    c = '{op: 6'h01, x1: 5'd0, x2: 5'd0, y: 5'd1, data: 32'h3f800000};
    drv_q.push_back(c);
    drain(50);
    chk("set_ready_len", last_len, 3);
    fix_en = 0;

    // Four back-to-back commands, latency 5
    lat = 5;
    for (int i = 0; i < 4; i++) drv_q.push_back(rnd_cmd());
    drain(200);
    chk("fmul_ready_len", last_len, 5);

    // Result backpressure stalls the second issue
    rr_mode = 0; lat = 2;
    drv_q.push_back(rnd_cmd());
    drv_q.push_back(rnd_cmd());
    run(15);
    chk("second_held", bus.busy && !bus.ready, 1);
    chk("res_held", bus.res_valid, 1);
    rr_mode = 1;
    drain(100);

    // FIFO fills while a held result stalls issue
    rr_mode = 0; lat = 1;
    drv_q.push_back(rnd_cmd());
    run(8);
    for (int i = 0; i < 5; i++) drv_q.push_back(rnd_cmd());
    run(10);
    chk("full_cmd_ready", bus.cmd_ready, 0);
    chk("fifth_not_taken", drv_q.size(), 1);
    rr_mode = 1;
    drain(200);

    // Valid on the final allowed cycle wins over timeout
    lat = TIMEOUT;
    drv_q.push_back(rnd_cmd());
    drain(100);
    chk("edge_ready_len", last_len, TIMEOUT);
    chk("edge_no_err", bus.err, 0);

    // FPU never answers: timeout
    lat = 0;
    drv_q.push_back(rnd_cmd());
    drain(100);
    chk("to_ready_len", last_len, TIMEOUT);
    chk("to_err", bus.err, 1);
    lat = 2;
    drv_q.push_back(rnd_cmd());
    drain(100);
    chk("after_to_ready_len", last_len, 2);

    // Randomized traffic with random latency and result backpressure
    rand_lat = 1; rr_mode = 2;
    for (int i = 0; i < 30; i++) drv_q.push_back(rnd_cmd());
    drain(3000);
    rand_lat = 0; rr_mode = 1;

    // Asynchronous reset in the middle of an issue with commands queued
    lat = 0;
    for (int i = 0; i < 3; i++) drv_q.push_back(rnd_cmd());
    for (int i = 0; i < 20 && !prev_ready; i++) cycle();
    run(2);
    chk("pre_rst_ready", bus.ready, 1);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", bus.ready, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_fields", {bus.operation, bus.x1, bus.x2, bus.y, bus.in_data}, 0);
    chk("arst_err", bus.err, 0);
    clear_model();
    bus.cmd_valid = 0;
    @(negedge clk);
    rstn = 1'b1;
    lat = 2;
    run(10);
    chk("post_rst_no_result", bus.res_valid, 0);
    drv_q.push_back(rnd_cmd());
    drain(100);
    chk("post_rst_ready_len", last_len, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
